// File: rtl/fifo_pkg.sv
// fifo_pkg: shared mode constants and count-width helper for stream_fifo
package fifo_pkg;
  localparam int FWFT   = 0;
  localparam int REGOUT = 1;
  // Count must reach DEPTH, plus one more when an output register adds capacity
  function automatic int fifo_cnt_w(input int depth, input int out_reg);
    return $clog2(depth + out_reg + 1);
  endfunction
endpackage

// File: rtl/stream_fifo_if.sv
// stream_fifo_if: valid/ready/data stream channel
//   master drives valid/data and samples ready; slave does the reverse
interface stream_fifo_if #(parameter type T = logic [7:0]) ();
  logic valid;
  logic ready;
  T     data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer with increment enable and synchronous clear
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear, wins over inc_i
//   inc_i      : advance pointer, wrapping DEPTH-1 -> 0
//   ptr_o      : current pointer
module fifo_wrap_ptr #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clr_i ? '0 : !inc_i ? ptr_q : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: parametrised synchronous FIFO with valid/ready streams on both sides
//   clk, rst_n     : clock, async active-low reset
//   flush_i        : synchronous clear of all contents, overrides push/pop
//   in_if          : producer stream (slave); ready = !full
//   out_if         : consumer stream (master); FWFT or registered head
//   count_o        : occupied entries including the output register
//   full_o         : memory array holds DEPTH entries
//   almost_full_o  : count >= AF_THRESH
//   almost_empty_o : count <= AE_THRESH
module stream_fifo import fifo_pkg::*; #(
  parameter int  DEPTH     = 8,
  parameter int  WIDTH     = 8,
  parameter type DTYPE     = logic [WIDTH-1:0],
  parameter int  OUT_REG   = FWFT,
  parameter int  AF_THRESH = DEPTH - 1,
  parameter int  AE_THRESH = 1,
  localparam int CW = fifo_cnt_w(DEPTH, OUT_REG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  stream_fifo_if.slave     in_if,
  stream_fifo_if.master    out_if,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int MW = $clog2(DEPTH + 1);
  DTYPE          mem [DEPTH];
  DTYPE          head;
  logic [PW-1:0] wptr, rptr;
  logic [MW-1:0] mem_cnt_q, mem_cnt_d;
  logic          push, pop, rd_adv, ov_q;
  assign full_o      = mem_cnt_q == MW'(DEPTH);
  assign in_if.ready = !full_o;
  assign push        = in_if.valid & in_if.ready;
  assign pop         = out_if.valid & out_if.ready;
  assign head        = mem[rptr];
  assign mem_cnt_d   = flush_i ? '0 : mem_cnt_q + MW'(push) - MW'(rd_adv);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_cnt_q <= '0;
    else        mem_cnt_q <= mem_cnt_d;
  always_ff @(posedge clk)
    if (push && !flush_i) mem[wptr] <= in_if.data;
  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (.clk, .rst_n, .clr_i(flush_i), .inc_i(push),   .ptr_o(wptr));
  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (.clk, .rst_n, .clr_i(flush_i), .inc_i(rd_adv), .ptr_o(rptr));
  if (OUT_REG == REGOUT) begin : g_reg
    DTYPE oreg_q;
    logic load;
    // Refill the output stage whenever it is empty or being drained this cycle
    assign load = (mem_cnt_q != '0) && (!ov_q || pop);
    assign rd_adv = load;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ov_q   <= 1'b0;
        oreg_q <= '0;
      end else begin
        ov_q   <= flush_i ? 1'b0 : load ? 1'b1 : pop ? 1'b0 : ov_q;
        oreg_q <= load ? head : oreg_q;
      end
    assign out_if.valid = ov_q;
    assign out_if.data  = oreg_q;
  end else begin : g_fwft
    assign ov_q         = 1'b0;
    assign rd_adv       = pop;
    assign out_if.valid = mem_cnt_q != '0;
    assign out_if.data  = head;
  end
  assign count_o        = CW'(mem_cnt_q) + CW'(ov_q);
  assign almost_full_o  = int'(count_o) >= AF_THRESH;
  assign almost_empty_o = int'(count_o) <= AE_THRESH;
endmodule
